// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (read-only) and the data
//   memory stage (read/write). One transaction is in flight at a time. The
//   memory command is registered, and mem_en is a single-cycle strobe. Data
//   has priority. Fetch is forced through after STARVE_MAX consecutive data
//   grants that were made while fetch was waiting. Protocol violations set the
//   sticky err flag.
//
//   Optional feature: define ARB_TIMEOUT_EN to abort a WAIT that has seen no
//   mem_done for TIMEOUT cycles. The abort sets err, issues no done and
//   re-arbitrates.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch read request (level) and address
//   if_done, if_stall        fetch completion pulse, fetch hold
//   dm_req/dm_wr/dm_addr/    data request (level), write flag, address,
//   dm_wdata                 write data
//   dm_done, dm_stall        data completion pulse, data-stage hold
//   rdata                    read data, valid with if_done/dm_done, else 0
//   mem_en/mem_wr/mem_addr/  registered memory command
//   mem_wdata
//   mem_done, mem_rdata      memory completion pulse and read data
//   err                      sticky protocol error
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic              dm_stall,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam logic       S_IDLE   = 1'b0;
  localparam logic       S_WAIT   = 1'b1;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_DM   = 2'b10;

  logic              r_state;
  logic [1:0]        r_owner;
  logic              r_mem_en;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_err;
  logic [3:0]        r_starve;
  logic              r_dropped;

  logic w_idle, w_wait, w_starved;
  logic w_grant_if, w_grant_dm;
  logic w_owner_req, w_drop, w_complete, w_deliver;
  logic w_timeout, w_err_evt;

  assign w_idle    = (r_state == S_IDLE);
  assign w_wait    = (r_state == S_WAIT);
  assign w_starved = (r_starve == 4'(STARVE_MAX));

  assign w_grant_if = w_idle & if_req & (~dm_req | w_starved);
  assign w_grant_dm = w_idle & dm_req & ~w_grant_if;

  always_comb begin
    w_owner_req = 1'b0;
    if (r_owner == OWN_IF) w_owner_req = if_req;
    else if (r_owner == OWN_DM) w_owner_req = dm_req;
  end

  // A dropped request still lets the memory finish, but its done is withheld
  // for the rest of the transaction, even if the request comes back.
  assign w_drop     = w_wait & ~w_owner_req;
  assign w_complete = w_wait & mem_done;
  assign w_deliver  = w_complete & ~r_dropped & ~w_drop;

  assign if_done  = w_deliver & (r_owner == OWN_IF);
  assign dm_done  = w_deliver & (r_owner == OWN_DM);
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;
  assign rdata    = ((if_done | dm_done) & ~r_mem_wr) ? mem_rdata : '0;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tcnt;

  // r_tcnt is 0 in the first WAIT cycle, so the abort lands on WAIT cycle TIMEOUT.
  assign w_timeout = w_wait & ~mem_done & (r_tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || w_idle) r_tcnt <= '0;
    else               r_tcnt <= r_tcnt + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_err_evt = (w_idle & mem_done) | (mem_done & r_mem_en) | w_drop | w_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_NONE;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_err       <= 1'b0;
      r_starve    <= '0;
      r_dropped   <= 1'b0;
    end else begin
      r_mem_en <= 1'b0;
      if (w_grant_if || w_grant_dm) begin
        r_state   <= S_WAIT;
        r_mem_en  <= 1'b1;
        r_mem_wr  <= w_grant_dm & dm_wr;
        r_dropped <= 1'b0;
        if (w_grant_if) begin
          r_owner    <= OWN_IF;
          r_mem_addr <= if_addr;
          r_starve   <= '0;
        end else begin
          r_owner     <= OWN_DM;
          r_mem_addr  <= dm_addr;
          r_mem_wdata <= dm_wdata;
          if (!if_req)         r_starve <= '0;
          else if (!w_starved) r_starve <= r_starve + 1'b1;
        end
      end else if (w_complete || w_timeout) begin
        r_state <= S_IDLE;
        r_owner <= OWN_NONE;
      end
      if (w_drop)    r_dropped <= 1'b1;
      if (w_err_evt) r_err     <= 1'b1;
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. The bench plays the memory, and every
//   expected value is hand-computed. Inputs change and outputs are sampled 1ns
//   after the rising edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_done, if_stall;
  logic        dm_req, dm_wr;
  logic [15:0] dm_addr, dm_wdata;
  logic        dm_done, dm_stall;
  logic [15:0] rdata;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_done;
  logic [15:0] mem_rdata;
  logic        err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  localparam logic [15:0] FA = 16'h0040;
  localparam logic [15:0] DA = 16'h2000;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(4), .TIMEOUT(31)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_stall(dm_stall), .rdata(rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Starts in an IDLE cycle with the requests already set up. Runs one
  // latency-1 transaction and returns in the next IDLE cycle.
  task automatic run_txn(input string tag, input logic exp_fetch);
    tick();
    chk({tag, "_en"}, 32'(mem_en), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), exp_fetch ? 32'(FA) : 32'(DA));
    tick();
    mem_done  = 1'b1;
    mem_rdata = 16'hA5A5;
    #1;
    chk({tag, "_ifdone"}, 32'(if_done), 32'(exp_fetch));
    chk({tag, "_dmdone"}, 32'(dm_done), 32'(!exp_fetch));
    tick();
    mem_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = FA; dm_req = 1'b0; dm_wr = 1'b0;
    dm_addr = DA; dm_wdata = '0; mem_done = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_en", 32'(mem_en), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);

    // Fetch only, L = 3
    if_req = 1'b1; #1;
    chk("f_stall0", 32'(if_stall), 32'd1);
    tick();
    chk("f_en1", 32'(mem_en), 32'd1);
    chk("f_addr1", 32'(mem_addr), 32'h0040);
    chk("f_wr1", 32'(mem_wr), 32'd0);
    chk("f_stall1", 32'(if_stall), 32'd1);
    tick();
    chk("f_en2", 32'(mem_en), 32'd0);
    chk("f_addr2", 32'(mem_addr), 32'h0040);
    tick();
    chk("f_done3", 32'(if_done), 32'd0);
    chk("f_stall3", 32'(if_stall), 32'd1);
    tick();
    mem_done = 1'b1; mem_rdata = 16'hBEEF; #1;
    chk("f_done4", 32'(if_done), 32'd1);
    chk("f_rdata4", 32'(rdata), 32'hBEEF);
    chk("f_stall4", 32'(if_stall), 32'd0);
    chk("f_dmdone4", 32'(dm_done), 32'd0);
    tick();
    mem_done = 1'b0; if_req = 1'b0; #1;
    chk("f_done5", 32'(if_done), 32'd0);
    chk("f_rdata5", 32'(rdata), 32'd0);
    tick();
    chk("f_nogrant", 32'(mem_en), 32'd0);

    // Data write, L = 1
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h1000; dm_wdata = 16'h1234;
    tick();
    chk("w_en", 32'(mem_en), 32'd1);
    chk("w_wr", 32'(mem_wr), 32'd1);
    chk("w_addr", 32'(mem_addr), 32'h1000);
    chk("w_wdata", 32'(mem_wdata), 32'h1234);
    tick();
    chk("w_stall", 32'(dm_stall), 32'd1);
    mem_done = 1'b1; mem_rdata = 16'h5555; #1;
    chk("w_done", 32'(dm_done), 32'd1);
    chk("w_rdata", 32'(rdata), 32'd0);
    chk("w_stall_done", 32'(dm_stall), 32'd0);
    tick();
    mem_done = 1'b0; dm_req = 1'b0; dm_wr = 1'b0; dm_addr = DA;
    chk("w_err", 32'(err), 32'd0);

    // Both requests held: D D D D F D D D D F
    if_req = 1'b1; dm_req = 1'b1;
    for (int unsigned k = 0; k < 10; k++)
      run_txn($sformatf("arb%0d", k), (k % 5) == 4);
    chk("arb_err", 32'(err), 32'd0);

    // A data grant while fetch is idle clears the starve count
    do_reset();
    for (int unsigned k = 0; k < 3; k++) run_txn($sformatf("clrA%0d", k), 1'b0);
    if_req = 1'b0;
    run_txn("clrB", 1'b0);
    if_req = 1'b1;
    for (int unsigned k = 0; k < 5; k++) run_txn($sformatf("clrC%0d", k), k == 4);
    if_req = 1'b0; dm_req = 1'b0;
    do_reset();

    // mem_done while IDLE
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("idle_done_err", 32'(err), 32'd1);
    tick(); tick();
    chk("err_sticky", 32'(err), 32'd1);
    do_reset();
    chk("err_clr", 32'(err), 32'd0);

    // mem_done in the same cycle as mem_en
    if_req = 1'b1;
    tick();
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0; if_req = 1'b0;
    chk("early_done_err", 32'(err), 32'd1);
    do_reset();

    // Owner drops its request while in WAIT: done suppressed, err set
    dm_req = 1'b1;
    tick(); tick();
    dm_req = 1'b0;
    tick();
    mem_done = 1'b1; #1;
    chk("drop_nodone", 32'(dm_done), 32'd0);
    tick();
    mem_done = 1'b0;
    chk("drop_err", 32'(err), 32'd1);
    do_reset();

    // Reset in WAIT abandons the transaction
    if_req = 1'b1; if_addr = 16'h0080;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_en", 32'(mem_en), 32'd0);
    chk("rstw_done", 32'(if_done), 32'd0);
    tick();
    chk("rstw_regrant", 32'(mem_en), 32'd1);
    chk("rstw_addr", 32'(mem_addr), 32'h0080);
    tick();
    mem_done = 1'b1; #1;
    chk("rstw_fdone", 32'(if_done), 32'd1);
    tick();
    mem_done = 1'b0; if_req = 1'b0; if_addr = FA;
    tick();

    // Memory never responds
    dm_req = 1'b1;
    tick();
    chk("to_en", 32'(mem_en), 32'd1);
`ifdef ARB_TIMEOUT_EN
    for (int unsigned k = 0; k < 30; k++) tick();
    chk("to_err_before", 32'(err), 32'd0);
    tick();
    chk("to_err", 32'(err), 32'd1);
    chk("to_nodone", 32'(dm_done), 32'd0);
    tick();
    chk("to_retry", 32'(mem_en), 32'd1);
    chk("to_stall", 32'(dm_stall), 32'd1);
`else
    for (int unsigned k = 0; k < 40; k++) tick();
    chk("hang_err", 32'(err), 32'd0);
    chk("hang_en", 32'(mem_en), 32'd0);
    chk("hang_stall", 32'(dm_stall), 32'd1);
`endif
    dm_req = 1'b0;
    do_reset();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
